// File: rtl/btn_pulse_gen.sv
// Push-button conditioner: 2-flop synchronizer, per-channel debounce FSM and press-pulse generator.
// Optional auto-repeat strobes are built when BTN_AUTOREPEAT_EN is defined.
module btn_pulse_gen #(
  parameter int unsigned NBTN          = 2,
  parameter int unsigned DB_CYCLES     = 500000,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic            CLK1,
  input  logic            RST,
  input  logic [NBTN-1:0] BTN,
  output logic [NBTN-1:0] PRESSED,
  output logic [NBTN-1:0] PULSE
);

  localparam int unsigned     CntW   = $clog2(DB_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

  if (DB_CYCLES < 2) begin : g_bad_db
    $error("DB_CYCLES must be at least 2");
  end
  if (REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_rpt
    $error("REPEAT_DELAY and REPEAT_PERIOD must be non-zero");
  end

  typedef enum logic {StReleased, StHeld} state_e;

  logic   [NBTN-1:0] sync1_q, sync2_q;
  state_e            state_q [NBTN];
  state_e            state_d [NBTN];
  logic   [CntW-1:0] cnt_q   [NBTN];
  logic   [CntW-1:0] cnt_d   [NBTN];
  logic   [NBTN-1:0] mismatch;
  logic   [NBTN-1:0] press_evt;
  logic   [NBTN-1:0] rpt_evt;
  logic   [NBTN-1:0] pulse_d, pulse_q;

  // Synchronizer idles at 1 so a reset looks like "all released".
  always_ff @(posedge CLK1) begin
    if (RST) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= BTN;
      sync2_q <= sync1_q;
    end
  end

  // A sample disagreeing with the current state advances the count; agreement restarts it.
  always_comb begin
    for (int i = 0; i < NBTN; i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      press_evt[i] = 1'b0;
      mismatch[i]  = (state_q[i] == StReleased) ? ~sync2_q[i] : sync2_q[i];
      if (!mismatch[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        cnt_d[i]     = '0;
        state_d[i]   = (state_q[i] == StReleased) ? StHeld : StReleased;
        press_evt[i] = (state_q[i] == StReleased);
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned     RptW      = $clog2(REPEAT_DELAY + REPEAT_PERIOD);
  localparam logic [RptW-1:0] RptFirst  = RptW'(REPEAT_DELAY - 1);
  localparam logic [RptW-1:0] RptNext   = RptW'(REPEAT_DELAY + REPEAT_PERIOD - 1);
  localparam logic [RptW-1:0] RptReload = RptW'(REPEAT_DELAY);

  logic [RptW-1:0] rpt_q [NBTN];
  logic [RptW-1:0] rpt_d [NBTN];

  // After each repeat the counter reloads to REPEAT_DELAY, so it never wraps while held.
  always_comb begin
    for (int i = 0; i < NBTN; i++) begin
      rpt_d[i]   = rpt_q[i];
      rpt_evt[i] = 1'b0;
      if (state_q[i] == StReleased) begin
        rpt_d[i] = '0;
      end else if (rpt_q[i] == RptFirst || rpt_q[i] == RptNext) begin
        rpt_evt[i] = 1'b1;
        rpt_d[i]   = RptReload;
      end else begin
        rpt_d[i] = rpt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK1) begin
    for (int i = 0; i < NBTN; i++) begin
      if (RST) begin
        rpt_q[i] <= '0;
      end else begin
        rpt_q[i] <= rpt_d[i];
      end
    end
  end
`else
  assign rpt_evt = '0;
`endif

  assign pulse_d = press_evt | rpt_evt;

  always_ff @(posedge CLK1) begin
    if (RST) begin
      pulse_q <= '0;
    end else begin
      pulse_q <= pulse_d;
    end
  end

  always_ff @(posedge CLK1) begin
    for (int i = 0; i < NBTN; i++) begin
      if (RST) begin
        state_q[i] <= StReleased;
        cnt_q[i]   <= '0;
      end else begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NBTN; i++) begin
      PRESSED[i] = (state_q[i] == StHeld);
    end
  end

  assign PULSE = pulse_q;

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Directed bench for btn_pulse_gen (DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8).
// Step k drives inputs before edge k and expects the outputs seen just after that edge.
module tb_btn_pulse_gen;

`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       CLK1 = 1'b0;
  logic       RST  = 1'b1;
  logic [1:0] BTN  = 2'b11;
  logic [1:0] PRESSED, PULSE;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  btn_pulse_gen #(
    .NBTN         (2),
    .DB_CYCLES    (4),
    .REPEAT_DELAY (20),
    .REPEAT_PERIOD(8)
  ) dut (
    .CLK1   (CLK1),
    .RST    (RST),
    .BTN    (BTN),
    .PRESSED(PRESSED),
    .PULSE  (PULSE)
  );

  always #5 CLK1 = ~CLK1;

  task automatic cyc(input string tag, input int k, input logic [1:0] btn_v, input logic rst_v,
                     input logic [1:0] ep, input logic [1:0] eu);
    logic [3:0] e;
    BTN = btn_v;
    RST = rst_v;
    exp_q.push_back({ep, eu});
    @(posedge CLK1);
    #1;
    e = exp_q.pop_front();
    checks++;
    assert (PRESSED === e[3:2]) else begin
      errors++;
      $error("FAIL %s_pressed step %0d got %b expected %b", tag, k, PRESSED, e[3:2]);
    end
    checks++;
    assert (PULSE === e[1:0]) else begin
      errors++;
      $error("FAIL %s_pulse step %0d got %b expected %b", tag, k, PULSE, e[1:0]);
    end
  endtask

  initial begin
    logic [1:0] b, ep, eu;

    // Reset: two cycles asserted, then idle released.
    for (int k = 0; k < 6; k++) cyc("reset", k, 2'b11, k < 2, 2'b00, 2'b00);

    // Clean press on channel 0, held 50 steps; repeats expected only in auto-repeat builds.
    for (int k = 0; k < 72; k++) begin
      b  = (k < 50) ? 2'b10 : 2'b11;
      ep = (k >= 5 && k < 55) ? 2'b01 : 2'b00;
      eu = (k == 5 || (AR && (k == 25 || k == 33 || k == 41 || k == 49))) ? 2'b01 : 2'b00;
      cyc("press", k, b, 1'b0, ep, eu);
    end

    // Bounce on channel 1: 2-cycle phases never reach the threshold.
    for (int k = 0; k < 30; k++) begin
      b = (k < 20 && ((k / 2) % 2 == 0)) ? 2'b01 : 2'b11;
      cyc("bounce", k, b, 1'b0, 2'b00, 2'b00);
    end

    // Simultaneous press and release of both buttons.
    for (int k = 0; k < 30; k++) begin
      b  = (k < 15) ? 2'b00 : 2'b11;
      ep = (k >= 5 && k < 20) ? 2'b11 : 2'b00;
      eu = (k == 5) ? 2'b11 : 2'b00;
      cyc("simul", k, b, 1'b0, ep, eu);
    end

    // Reset while channel 0 is held: cleared, then re-detected as a fresh press.
    for (int k = 0; k < 34; k++) begin
      b  = (k < 20) ? 2'b10 : 2'b11;
      ep = ((k >= 5 && k < 8) || (k >= 14 && k < 25)) ? 2'b01 : 2'b00;
      eu = (k == 5 || k == 14) ? 2'b01 : 2'b00;
      cyc("rstmid", k, b, k == 8, ep, eu);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
